// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch queue: default widths,
// jump opcodes, the queue entry layout and a jump-decode helper.
package fetch_pkg;

  localparam int ADDR_W_DEF  = 5;
  localparam int INSTR_W_DEF = 32;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  // One queued fetch result: the ROM address and the word read from it.
  typedef struct packed {
    logic [ADDR_W_DEF-1:0]  pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

  // True for the unconditional jump opcodes decode cares about early.
  function automatic logic is_jump_op(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the PC/ROM pair, the fetch queue and decode.
// master = the environment driving ROM data, flush and decode ready;
// slave  = the fetch queue itself.
interface fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic               inValid;
  logic [ADDR_W-1:0]  inPc;
  logic [INSTR_W-1:0] inInstr;
  logic               flush;
  logic               outReady;
  logic               outValid;
  logic [ADDR_W-1:0]  outPc;
  logic [INSTR_W-1:0] outInstr;
  logic [5:0]         outOpcode;
  logic               outIsJump;
  logic               pcEnable;
  logic [CNT_W-1:0]   count;
  logic               overflow;

  modport master (
    output inValid, inPc, inInstr, flush, outReady,
    input  outValid, outPc, outInstr, outOpcode, outIsJump, pcEnable, count, overflow
  );

  modport slave (
    input  inValid, inPc, inInstr, flush, outReady,
    output outValid, outPc, outInstr, outOpcode, outIsJump, pcEnable, count, overflow
  );

endinterface

// File: rtl/fetch_ram.sv
// Queue storage: register array with a synchronous write port and an
// asynchronous read port so the head entry falls through without delay.
// Contents are deliberately not reset; validity is tracked by the pointers.
module fetch_ram
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ADDR_W_DEF + INSTR_W_DEF,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the pushed entry into its slot on the clock edge.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between the PC/ROM pair and decode. Buffers
// {pc, instr} words, presents them first-word fall-through, throttles the
// PC so the in-flight ROM read always has a slot, and drops wrong-path
// words (including the one stale read still in flight) on a redirect.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = ADDR_W + INSTR_W;

  localparam logic [CNT_W-1:0] CNT_ZERO     = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(DEPTH);
  // Highest fill level at which a new fetch may still be issued: one slot
  // must stay free for the ROM read that is already under way.
  localparam logic [CNT_W-1:0] CNT_PCEN_MAX = CNT_W'(DEPTH - 2);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             drop_next_q, drop_next_d;
  logic             overflow_q, overflow_d;

  logic             push_s;
  logic             pop_s;
  logic             empty_s;
  logic             full_s;
  logic             wr_en_s;
  logic [ENT_W-1:0] rd_data_s;
  logic [5:0]       opcode_s;

  assign empty_s = (count_q == CNT_ZERO);
  assign full_s  = (count_q == CNT_FULL);
  assign push_s  = bus.inValid && !bus.flush && !drop_next_q;
  assign pop_s   = !empty_s && bus.outReady && !bus.flush;
  // A full queue can still take a word if the head leaves in the same cycle.
  assign wr_en_s = push_s && (!full_s || pop_s);

  fetch_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en_s),
    .waddr_i (wr_ptr_q),
    .wdata_i ({bus.inPc, bus.inInstr}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data_s)
  );

  // Next-state for pointers, occupancy and flags; a flush overrides push/pop.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    drop_next_d = drop_next_q;
    overflow_d  = overflow_q;
    if (bus.flush) begin
      wr_ptr_d    = PTR_W'(0);
      rd_ptr_d    = PTR_W'(0);
      count_d     = CNT_ZERO;
      drop_next_d = 1'b1;
    end else begin
      drop_next_d = 1'b0;
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (push_s && !wr_en_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= PTR_W'(0);
      rd_ptr_q    <= PTR_W'(0);
      count_q     <= CNT_ZERO;
      drop_next_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      drop_next_q <= drop_next_d;
      overflow_q  <= overflow_d;
    end
  end

  assign opcode_s      = rd_data_s[31:26];
  assign bus.outValid  = !empty_s;
  assign bus.outPc     = rd_data_s[ENT_W-1 -: ADDR_W];
  assign bus.outInstr  = rd_data_s[INSTR_W-1:0];
  assign bus.outOpcode = opcode_s;
  assign bus.outIsJump = is_jump_op(opcode_s);
  assign bus.pcEnable  = (count_q <= CNT_PCEN_MAX);
  assign bus.count     = count_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fill, overflow, drain, wrap-around with
// simultaneous push/pop, flush with stale-word drop, and mid-stream reset.
module tb_fetch_queue;
  import fetch_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  fetch_queue_if #(.DEPTH(4)) bus ();

  fetch_queue #(.DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence never completes.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] pc, input logic [31:0] instr);
    bus.inValid = v;
    bus.inPc    = pc;
    bus.inInstr = instr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.outReady = 1'b0;
    drive(1'b0, 5'd0, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL reset_outValid got %b want 0", bus.outValid); end
    n_cmp++; if (bus.pcEnable !== 1'b1) begin n_err++; $display("FAIL reset_pcEnable got %b want 1", bus.pcEnable); end
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", bus.count); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
  endtask

  task automatic test_fill();
    drive(1'b1, 5'd0, 32'h20080005);
    tick();
    n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL fill_count1 got %0d want 1", bus.count); end
    n_cmp++; if (bus.outValid !== 1'b1) begin n_err++; $display("FAIL fill_outValid got %b want 1", bus.outValid); end
    n_cmp++; if (bus.outOpcode !== 6'h08) begin n_err++; $display("FAIL fill_opcode got %h want 08", bus.outOpcode); end
    n_cmp++; if (bus.pcEnable !== 1'b1) begin n_err++; $display("FAIL fill_pcEn1 got %b want 1", bus.pcEnable); end
    drive(1'b1, 5'd1, 32'h08000004);
    tick();
    n_cmp++; if (bus.count !== 3'd2) begin n_err++; $display("FAIL fill_count2 got %0d want 2", bus.count); end
    n_cmp++; if (bus.pcEnable !== 1'b1) begin n_err++; $display("FAIL fill_pcEn2 got %b want 1", bus.pcEnable); end
    drive(1'b1, 5'd2, 32'h00000000);
    tick();
    n_cmp++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL fill_count3 got %0d want 3", bus.count); end
    n_cmp++; if (bus.pcEnable !== 1'b0) begin n_err++; $display("FAIL fill_pcEn3 got %b want 0", bus.pcEnable); end
    n_cmp++; if (bus.outPc !== 5'd0) begin n_err++; $display("FAIL fill_headPc got %0d want 0", bus.outPc); end
    n_cmp++; if (bus.outIsJump !== 1'b0) begin n_err++; $display("FAIL fill_isJump got %b want 0", bus.outIsJump); end
  endtask

  task automatic test_overflow_drain();
    fetch_entry_t exp [4];
    logic         exp_jmp [4];
    exp[0] = '{pc: 5'd0, instr: 32'h20080005}; exp_jmp[0] = 1'b0;
    exp[1] = '{pc: 5'd1, instr: 32'h08000004}; exp_jmp[1] = 1'b1;
    exp[2] = '{pc: 5'd2, instr: 32'h00000000}; exp_jmp[2] = 1'b0;
    exp[3] = '{pc: 5'd3, instr: 32'h0C000001}; exp_jmp[3] = 1'b1;
    drive(1'b1, 5'd3, 32'h0C000001);
    tick();
    n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL ovf_count4 got %0d want 4", bus.count); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL ovf_notyet got %b want 0", bus.overflow); end
    drive(1'b1, 5'd10, 32'hDEADBEEF);
    tick();
    n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL ovf_countStay got %0d want 4", bus.count); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
    drive(1'b0, 5'd0, 32'h0);
    bus.outReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.outPc !== exp[i].pc) begin n_err++; $display("FAIL drain_pc[%0d] got %0d want %0d", i, bus.outPc, exp[i].pc); end
      n_cmp++; if (bus.outInstr !== exp[i].instr) begin n_err++; $display("FAIL drain_instr[%0d] got %h want %h", i, bus.outInstr, exp[i].instr); end
      n_cmp++; if (bus.outIsJump !== exp_jmp[i]) begin n_err++; $display("FAIL drain_jmp[%0d] got %b want %b", i, bus.outIsJump, exp_jmp[i]); end
      tick();
    end
    bus.outReady = 1'b0;
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL drain_count got %0d want 0", bus.count); end
    n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL drain_outValid got %b want 0", bus.outValid); end
    n_cmp++; if (bus.pcEnable !== 1'b1) begin n_err++; $display("FAIL drain_pcEn got %b want 1", bus.pcEnable); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL drain_ovfSticky got %b want 1", bus.overflow); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_pc [4];
    exp_pc[0] = 5'd2; exp_pc[1] = 5'd3; exp_pc[2] = 5'd4; exp_pc[3] = 5'd5;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(i), 32'hA0000000 + 32'(i));
      tick();
    end
    n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL b2b_full got %0d want 4", bus.count); end
    bus.outReady = 1'b1;
    drive(1'b1, 5'd4, 32'hA0000004);
    n_cmp++; if (bus.outPc !== 5'd0) begin n_err++; $display("FAIL b2b_head0 got %0d want 0", bus.outPc); end
    tick();
    n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL b2b_count_a got %0d want 4", bus.count); end
    n_cmp++; if (bus.outPc !== 5'd1) begin n_err++; $display("FAIL b2b_head1 got %0d want 1", bus.outPc); end
    drive(1'b1, 5'd5, 32'hA0000005);
    tick();
    n_cmp++; if (bus.count !== 3'd4) begin n_err++; $display("FAIL b2b_count_b got %0d want 4", bus.count); end
    drive(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.outPc !== exp_pc[i]) begin n_err++; $display("FAIL b2b_order[%0d] got %0d want %0d", i, bus.outPc, exp_pc[i]); end
      n_cmp++; if (bus.outInstr !== (32'hA0000000 + 32'(exp_pc[i]))) begin n_err++; $display("FAIL b2b_instr[%0d] got %h want %h", i, bus.outInstr, 32'hA0000000 + 32'(exp_pc[i])); end
      tick();
    end
    bus.outReady = 1'b0;
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL b2b_empty got %0d want 0", bus.count); end
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd20, 32'h11111111);
    tick();
    drive(1'b1, 5'd21, 32'h22222222);
    tick();
    n_cmp++; if (bus.count !== 3'd2) begin n_err++; $display("FAIL flush_pre got %0d want 2", bus.count); end
    bus.flush = 1'b1;
    drive(1'b1, 5'd6, 32'h66666666);
    tick();
    bus.flush = 1'b0;
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL flush_count got %0d want 0", bus.count); end
    n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL flush_outValid got %b want 0", bus.outValid); end
    drive(1'b1, 5'd7, 32'h77777777);
    tick();
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL flush_stale got %0d want 0", bus.count); end
    drive(1'b1, 5'd9, 32'h08000009);
    tick();
    n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL flush_accept got %0d want 1", bus.count); end
    n_cmp++; if (bus.outPc !== 5'd9) begin n_err++; $display("FAIL flush_headPc got %0d want 9", bus.outPc); end
    n_cmp++; if (bus.outIsJump !== 1'b1) begin n_err++; $display("FAIL flush_headJmp got %b want 1", bus.outIsJump); end
    drive(1'b0, 5'd0, 32'h0);
    bus.outReady = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL pop_empty got %0d want 0", bus.count); end
    bus.outReady = 1'b0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b1, 5'd11, 32'hBBBBBBBB);
    tick();
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL flushEmpty_stale got %0d want 0", bus.count); end
    drive(1'b1, 5'd13, 32'hCCCCCCCC);
    tick();
    n_cmp++; if (bus.outPc !== 5'd13) begin n_err++; $display("FAIL flushEmpty_accept got %0d want 13", bus.outPc); end
    drive(1'b0, 5'd0, 32'h0);
    bus.outReady = 1'b1;
    tick();
    bus.outReady = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i < 4; i++) begin
      drive(1'b1, 5'(i), 32'h30000000 + 32'(i));
      tick();
    end
    n_cmp++; if (bus.count !== 3'd3) begin n_err++; $display("FAIL rmid_pre got %0d want 3", bus.count); end
    n_cmp++; if (bus.overflow !== 1'b1) begin n_err++; $display("FAIL rmid_ovfPre got %b want 1", bus.overflow); end
    rst = 1'b1;
    bus.flush = 1'b1;
    drive(1'b1, 5'd8, 32'h88888888);
    tick();
    rst = 1'b0;
    bus.flush = 1'b0;
    n_cmp++; if (bus.count !== 3'd0) begin n_err++; $display("FAIL rmid_count got %0d want 0", bus.count); end
    n_cmp++; if (bus.outValid !== 1'b0) begin n_err++; $display("FAIL rmid_outValid got %b want 0", bus.outValid); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_err++; $display("FAIL rmid_overflow got %b want 0", bus.overflow); end
    n_cmp++; if (bus.pcEnable !== 1'b1) begin n_err++; $display("FAIL rmid_pcEn got %b want 1", bus.pcEnable); end
    drive(1'b1, 5'd14, 32'h12345678);
    tick();
    drive(1'b0, 5'd0, 32'h0);
    n_cmp++; if (bus.count !== 3'd1) begin n_err++; $display("FAIL rmid_push got %0d want 1", bus.count); end
    n_cmp++; if (bus.outPc !== 5'd14) begin n_err++; $display("FAIL rmid_headPc got %0d want 14", bus.outPc); end
    n_cmp++; if (bus.outInstr !== 32'h12345678) begin n_err++; $display("FAIL rmid_headInstr got %h want 12345678", bus.outInstr); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_fill();
    test_overflow_drain();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
